// File: rtl/code_loader_pkg.sv
// code_loader_pkg: shared types and constants for the code loader.
//   state_t    - loader FSM states
//   LEN_BYTES  - bytes in the frame length field
//   WORD_BYTES - bytes per code word on the stream
//   CSUM_W     - width of the running frame checksum
//   csum_add() - modulo-2^CSUM_W checksum accumulate helper
package code_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_LO  = 3'd1,
    LEN_HI  = 3'd2,
    WORD_LO = 3'd3,
    WORD_HI = 3'd4,
    CHECK   = 3'd5,
    DONE    = 3'd6,
    ERROR   = 3'd7
  } state_t;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 2;
  localparam int CSUM_W     = 8;

  // Running checksum: plain 8-bit sum, wrap-around intended.
  function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                 input logic [7:0]        b);
    return acc + b;
  endfunction

endpackage

// File: rtl/code_loader.sv
// code_loader: parses a length-prefixed program frame from a byte stream and
// writes the assembled code words into code storage.
//
// Frame: N[7:0], N[15:8], then N words as (low byte, high byte).
// Word = {hi[code_size-9:0], lo}; unused high bits are dropped.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   start                 - pulse in IDLE begins a frame load
//   in_valid/in_data      - byte stream in; in_ready is decoded from state
//   is_write              - one-cycle storage write strobe
//   write_line/write_data - write address/data, held between strobes
//   core_hold             - high while a frame is being loaded
//   load_done/load_error  - sticky result of the last frame
//
// Optional build macro CODE_LOADER_CHECKSUM_EN: adds a trailing checksum
// byte; the 8-bit sum of all frame bytes must be zero for the frame to pass.
module code_loader
  import code_loader_pkg::*;
#(
  parameter int code_size     = 12,
  parameter int max_code_line = 100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 is_write,
  output logic [31:0]          write_line,
  output logic [code_size-1:0] write_data,
  output logic                 core_hold,
  output logic                 load_done,
  output logic                 load_error
);

  localparam int             LEN_W    = 8 * LEN_BYTES;
  localparam logic [LEN_W-1:0] MAX_LINE = LEN_W'(max_code_line);

`ifdef CODE_LOADER_CHECKSUM_EN
  localparam state_t FRAME_END = CHECK;
`else
  localparam state_t FRAME_END = DONE;
`endif

  state_t                 state_r;
  state_t                 next_state_s;
  logic [LEN_W-1:0]       len_r;
  logic [7:0]             lo_r;
  logic [LEN_W-1:0]       line_cnt_r;
  logic                   is_write_r;
  logic [31:0]            write_line_r;
  logic [code_size-1:0]   write_data_r;
  logic                   core_hold_r;
  logic                   load_done_r;
  logic                   load_error_r;
  logic                   in_ready_s;
  logic                   hold_s;
  logic                   accept_s;
  logic [LEN_W-1:0]       len_full_s;
  logic [LEN_W-1:0]       cnt_next_s;
  logic [code_size-1:0]   word_s;

`ifdef CODE_LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0]      csum_r;
  logic [CSUM_W-1:0]      csum_next_s;

  assign csum_next_s = csum_add(csum_r, in_data);
`endif

  assign accept_s   = in_valid && in_ready_s;
  assign len_full_s = {in_data, len_r[7:0]};
  assign cnt_next_s = line_cnt_r + 16'd1;
  assign word_s     = {in_data[code_size-9:0], lo_r};

  // Byte-accept window: only the states that consume stream bytes.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      LEN_LO, LEN_HI, WORD_LO, WORD_HI, CHECK: in_ready_s = 1'b1;
      default:                                 in_ready_s = 1'b0;
    endcase
  end

  // Sequencer hold decoded from the upcoming state so the register tracks state.
  always_comb begin
    hold_s = 1'b1;
    case (next_state_s)
      IDLE, DONE, ERROR: hold_s = 1'b0;
      default:           hold_s = 1'b1;
    endcase
  end

  // Frame parser next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = LEN_LO;
        else       next_state_s = IDLE;
      end
      LEN_LO: begin
        if (accept_s) next_state_s = LEN_HI;
        else          next_state_s = LEN_LO;
      end
      LEN_HI: begin
        if (!accept_s)                    next_state_s = LEN_HI;
        else if (len_full_s > MAX_LINE)   next_state_s = ERROR;
        else if (len_full_s == 16'd0)     next_state_s = FRAME_END;
        else                              next_state_s = WORD_LO;
      end
      WORD_LO: begin
        if (accept_s) next_state_s = WORD_HI;
        else          next_state_s = WORD_LO;
      end
      WORD_HI: begin
        if (!accept_s)                next_state_s = WORD_HI;
        else if (cnt_next_s == len_r) next_state_s = FRAME_END;
        else                          next_state_s = WORD_LO;
      end
      CHECK: begin
`ifdef CODE_LOADER_CHECKSUM_EN
        if (!accept_s)                   next_state_s = CHECK;
        else if (csum_next_s == 8'd0)    next_state_s = DONE;
        else                             next_state_s = ERROR;
`else
        next_state_s = IDLE;
`endif
      end
      DONE:    next_state_s = IDLE;
      ERROR:   next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, datapath capture and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      len_r        <= 16'd0;
      lo_r         <= 8'd0;
      line_cnt_r   <= 16'd0;
      is_write_r   <= 1'b0;
      write_line_r <= 32'd0;
      write_data_r <= '0;
      core_hold_r  <= 1'b0;
      load_done_r  <= 1'b0;
      load_error_r <= 1'b0;
`ifdef CODE_LOADER_CHECKSUM_EN
      csum_r       <= 8'd0;
`endif
    end else begin
      state_r     <= next_state_s;
      core_hold_r <= hold_s;
      is_write_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            load_done_r  <= 1'b0;
            load_error_r <= 1'b0;
            line_cnt_r   <= 16'd0;
`ifdef CODE_LOADER_CHECKSUM_EN
            csum_r       <= 8'd0;
`endif
          end
        end
        LEN_LO:  if (accept_s) len_r[7:0]  <= in_data;
        LEN_HI:  if (accept_s) len_r[15:8] <= in_data;
        WORD_LO: if (accept_s) lo_r        <= in_data;
        WORD_HI: begin
          if (accept_s) begin
            is_write_r   <= 1'b1;
            write_line_r <= {16'd0, line_cnt_r};
            write_data_r <= word_s;
            line_cnt_r   <= cnt_next_s;
          end
        end
        default: ;
      endcase
`ifdef CODE_LOADER_CHECKSUM_EN
      // Never accepting in IDLE, so this cannot collide with the start clear.
      if (accept_s) csum_r <= csum_next_s;
`endif
      if (next_state_s == DONE)  load_done_r  <= 1'b1;
      if (next_state_s == ERROR) load_error_r <= 1'b1;
    end
  end

  assign in_ready   = in_ready_s;
  assign is_write   = is_write_r;
  assign write_line = write_line_r;
  assign write_data = write_data_r;
  assign core_hold  = core_hold_r;
  assign load_done  = load_done_r;
  assign load_error = load_error_r;

endmodule

// File: tb/tb_code_loader.sv
// tb_code_loader: directed self-checking bench for code_loader.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge. A monitor logs every write strobe and counts core_hold cycles.
module tb_code_loader;

  localparam int CS = 12;
`ifdef CODE_LOADER_CHECKSUM_EN
  localparam int HOLD_N3 = 9;
`else
  localparam int HOLD_N3 = 8;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          is_write;
  logic [31:0]   write_line;
  logic [CS-1:0] write_data;
  logic          core_hold;
  logic          load_done;
  logic          load_error;

  int checks = 0;
  int errors = 0;
  int hold_cnt = 0;
  logic [31:0] wl_q[$];
  logic [31:0] wd_q[$];

  logic [7:0]  f3   [8] = '{8'h03, 8'h00, 8'h23, 8'h01, 8'h56, 8'h04, 8'hBC, 8'h0A};
  logic [31:0] exp3 [3] = '{32'h123, 32'h456, 32'hABC};

  code_loader #(.code_size(CS), .max_code_line(100)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .is_write(is_write),
    .write_line(write_line), .write_data(write_data), .core_hold(core_hold),
    .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (is_write) begin
      wl_q.push_back(write_line);
      wd_q.push_back(32'(write_data));
    end
    if (core_hold) hold_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int tries;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    tries = 0;
    while (!in_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    chk("byte_accept_bound", 32'(tries < 20), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_n3(input int gapmax, input bit mid_start);
    for (int i = 0; i < 8; i++) begin
      send_byte(f3[i], int'($urandom_range(0, gapmax)));
      if (mid_start && i == 1) begin
        pulse_start();
        chk("start_ignored_hold", 32'(core_hold), 32'd1);
      end
    end
`ifdef CODE_LOADER_CHECKSUM_EN
    send_byte(8'hB9, int'($urandom_range(0, gapmax)));
`endif
  endtask

  task automatic check_n3(input int base);
    chk("n3_write_count", 32'(wl_q.size() - base), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (base + i < wl_q.size()) begin
        chk("n3_line", wl_q[base+i], 32'(i));
        chk("n3_data", wd_q[base+i], exp3[i]);
      end
    end
  endtask

  initial begin
    int base;
    int hb;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_is_write", 32'(is_write), 32'd0);
    chk("rst_core_hold", 32'(core_hold), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_error", 32'(load_error), 32'd0);
    chk("rst_write_line", write_line, 32'd0);
    chk("rst_write_data", 32'(write_data), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Bytes offered while idle are not taken.
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    chk("idle_core_hold", 32'(core_hold), 32'd0);
    in_valid = 1'b0;

    // N=3, valid held high.
    base = wl_q.size(); hb = hold_cnt;
    pulse_start();
    chk("t1_hold_after_start", 32'(core_hold), 32'd1);
    send_n3(0, 1'b0);
    chk("t1_load_done", 32'(load_done), 32'd1);
    chk("t1_hold_drop", 32'(core_hold), 32'd0);
    @(negedge clk);
    chk("t1_in_ready_after", 32'(in_ready), 32'd0);
    chk("t1_load_error", 32'(load_error), 32'd0);
    chk("t1_hold_cycles", 32'(hold_cnt - hb), 32'(HOLD_N3));
    check_n3(base);

    // N=101 exceeds the line count.
    base = wl_q.size();
    pulse_start();
    chk("t2_done_cleared", 32'(load_done), 32'd0);
    send_byte(8'h65, 0);
    send_byte(8'h00, 0);
    chk("t2_load_error", 32'(load_error), 32'd1);
    chk("t2_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("t2_in_ready_idle", 32'(in_ready), 32'd0);
    chk("t2_load_done", 32'(load_done), 32'd0);
    chk("t2_no_writes", 32'(wl_q.size() - base), 32'd0);

    // N=0.
    base = wl_q.size();
    pulse_start();
    chk("t3_error_cleared", 32'(load_error), 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef CODE_LOADER_CHECKSUM_EN
    chk("t3_wait_check", 32'(core_hold), 32'd1);
    send_byte(8'h00, 0);
`endif
    chk("t3_load_done", 32'(load_done), 32'd1);
    @(negedge clk);
    chk("t3_load_error", 32'(load_error), 32'd0);
    chk("t3_no_writes", 32'(wl_q.size() - base), 32'd0);

    // N=3 with random valid gaps and a stray start mid-frame.
    base = wl_q.size();
    pulse_start();
    send_n3(3, 1'b1);
    chk("t4_load_done", 32'(load_done), 32'd1);
    repeat (2) @(negedge clk);
    chk("t4_load_error", 32'(load_error), 32'd0);
    check_n3(base);

    // Reset after the 4th byte.
    base = wl_q.size();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(f3[i], 0);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_in_ready", 32'(in_ready), 32'd0);
    chk("t5_is_write", 32'(is_write), 32'd0);
    chk("t5_core_hold", 32'(core_hold), 32'd0);
    chk("t5_load_done", 32'(load_done), 32'd0);
    chk("t5_write_line", write_line, 32'd0);
    chk("t5_write_data", 32'(write_data), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_one_write", 32'(wl_q.size() - base), 32'd1);
    if (wl_q.size() > base) begin
      chk("t5_line0", wl_q[base], 32'd0);
      chk("t5_data0", wd_q[base], 32'h123);
    end
    base = wl_q.size();
    pulse_start();
    send_n3(0, 1'b0);
    chk("t5_reload_done", 32'(load_done), 32'd1);
    @(negedge clk);
    check_n3(base);

`ifdef CODE_LOADER_CHECKSUM_EN
    // Checksum pass and fail on a one-word frame.
    base = wl_q.size();
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h34, 0); send_byte(8'h02, 0);
    send_byte(8'hC9, 0);
    chk("t6_pass_done", 32'(load_done), 32'd1);
    chk("t6_pass_error", 32'(load_error), 32'd0);
    base = wl_q.size();
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h34, 0); send_byte(8'h02, 0);
    send_byte(8'hC8, 0);
    chk("t6_fail_error", 32'(load_error), 32'd1);
    chk("t6_fail_done", 32'(load_done), 32'd0);
    @(negedge clk);
    chk("t6_fail_writes", 32'(wl_q.size() - base), 32'd1);
    if (wl_q.size() > base) begin
      chk("t6_fail_line", wl_q[base], 32'd0);
      chk("t6_fail_data", wd_q[base], 32'h234);
    end
    chk("t6_data_held", 32'(write_data), 32'h234);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
